// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_rr_arbiter : merges NumMasters OBI initiators onto one OBI request,  |
// | routing each response back through an in-order ID FIFO.                  |
// | Optional macro OBI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package obi_rr_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_rr_arbiter
  import obi_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumMasters     = 2,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned IdxW          = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NumMasters],
  output obi_resp_t master_resp_o [NumMasters],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      err_o
);

  localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumMasters - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] Depth   = CntW'(MaxOutstanding);

  logic            lock_v_q, lock_v_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];

  logic [IdxW-1:0] start_idx, arb_idx, cand, sel, head;
  logic            arb_found, cand_req, can_issue, fwd, hs, pop;

`ifdef OBI_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IdxW-1:0] rr_q, rr_d;

  assign start_idx = rr_q;
  assign rr_d      = hs ? ((sel == LastIdx) ? '0 : sel + 1'b1) : rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`endif

  // Search upward from start_idx, wrapping at the last real master index.
  always_comb begin
    arb_idx   = start_idx;
    arb_found = 1'b0;
    cand      = start_idx;
    for (int unsigned i = 0; i < NumMasters; i++) begin
      if (!arb_found && master_req_i[cand].req) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
    end
  end

  assign sel       = lock_v_q ? lock_idx_q : arb_idx;
  assign cand_req  = master_req_i[sel].req;
  assign can_issue = (count_q < Depth) || slave_resp_i.rvalid;
  assign fwd       = cand_req && can_issue && !rst_i;
  assign hs        = fwd && slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign slave_req_o = fwd ? master_req_i[sel] : '0;
  assign err_o       = err_q;

  always_comb begin
    for (int unsigned i = 0; i < NumMasters; i++) begin
      master_resp_o[i] = '0;
      if (hs && (sel == IdxW'(i))) master_resp_o[i].gnt = 1'b1;
      if (pop && (head == IdxW'(i))) begin
        master_resp_o[i].rvalid = 1'b1;
        master_resp_o[i].rdata  = slave_resp_i.rdata;
      end
    end
  end

  always_comb begin
    lock_v_d   = lock_v_q;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q | (slave_resp_i.rvalid && (count_q == '0));

    // Hold the stalled master until granted; release if it abandons its request.
    if (hs) begin
      lock_v_d = 1'b0;
    end else if (fwd) begin
      lock_v_d   = 1'b1;
      lock_idx_d = sel;
    end else if (lock_v_q && !cand_req) begin
      lock_v_d = 1'b0;
    end

    if (hs)  wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    if (hs && !pop)      count_d = count_q + 1'b1;
    else if (pop && !hs) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_v_q   <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_v_q   <= lock_v_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_ptr_q] <= sel;
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obi_rr_arbiter : directed scoreboard bench for obi_rr_arbiter.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_obi_rr_arbiter;
  import obi_rr_arbiter_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  obi_req_t  m_req  [2];
  obi_resp_t m_resp [2];
  obi_req_t  s_req;
  obi_resp_t s_resp;
  logic      err;

  int checks = 0;
  int errors = 0;
  int seq    = 0;

  typedef struct {
    int          m;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q   [$];
  logic [31:0] slave_q [$];

  always #5 clk = ~clk;

  obi_rr_arbiter #(.NumMasters(2), .MaxOutstanding(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .master_req_i (m_req),
    .master_resp_o(m_resp),
    .slave_req_o  (s_req),
    .slave_resp_i (s_resp),
    .err_o        (err)
  );

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (m_resp[m].rvalid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rvalid_unexpected: master %0d rvalid=1 required 0", m);
          end else begin
            e = exp_q.pop_front();
            if (e.m != m || e.data !== m_resp[m].rdata) begin
              errors++;
              $display("FAIL rvalid_route: got master %0d rdata %h, required master %0d rdata %h",
                       m, m_resp[m].rdata, e.m, e.data);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_gnt(input string nm, input int exp_m);
    for (int m = 0; m < 2; m++)
      chk(nm, 32'(m_resp[m].gnt), (m == exp_m) ? 32'd1 : 32'd0);
  endtask

  task automatic push_exp(input int m);
    logic [31:0] v;
    v = ((m == 1) ? 32'h0000_00B1 : 32'h0000_00A0) | (32'(seq) << 8);
    seq++;
    exp_q.push_back('{m, v});
    slave_q.push_back(v);
  endtask

  task automatic give_rvalid();
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0000_DEAD;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    s_resp.rvalid = 1'b0;
    s_resp.rdata  = '0;
  endtask

  task automatic set_m(input int m, input logic r, input logic [31:0] a);
    m_req[m].req   = r;
    m_req[m].we    = 1'b0;
    m_req[m].be    = 4'hF;
    m_req[m].addr  = a;
    m_req[m].wdata = '0;
  endtask

  task automatic idle();
    set_m(0, 1'b0, '0);
    set_m(1, 1'b0, '0);
    s_resp = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_req", 32'(s_req.req), 32'd0);
    tick();
    rst = 1'b0;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    slave_q.delete();
  endtask

  // Hand-derived grant order for the full-FIFO push/pop run (rr starts at 1).
  int mask_tab [10] = '{3, 1, 2, 3, 3, 2, 1, 3, 1, 2};
  int sel_tab  [10] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  initial begin
    idle();
    // Reset held with master 0 requesting and slave ready.
    set_m(0, 1'b1, 32'h10);
    s_resp.gnt = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req", 32'(s_req.req), 32'd0);
      chk_gnt("rst_gnt", -1);
      chk("rst_err", 32'(err), 32'd0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(s_req.req), 32'd1);
    chk("first_addr", s_req.addr, 32'h10);
    chk_gnt("first_gnt", 0);
    push_exp(0);
    tick();
    set_m(0, 1'b0, '0);
    give_rvalid();
    @(negedge clk);
    tick();

    // Round-robin alternation with one-cycle response latency.
    do_reset();
    s_resp.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1'b1, 32'h0);
      set_m(1, 1'b1, 32'h4);
      if (k > 0) give_rvalid();
      @(negedge clk);
      chk_gnt("rr_gnt", k % 2);
      push_exp(k % 2);
      tick();
    end
    idle();
    give_rvalid();
    @(negedge clk);
    tick();

    // Stability lock on master 1 while slave stalls.
    do_reset();
    s_resp.gnt = 1'b0;
    set_m(1, 1'b1, 32'h100);
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) set_m(0, 1'b1, 32'h200);
      @(negedge clk);
      chk("stable_addr", s_req.addr, 32'h100);
      chk_gnt("stable_nognt", -1);
      tick();
    end
    s_resp.gnt = 1'b1;
    @(negedge clk);
    chk_gnt("stable_first", 1);
    push_exp(1);
    tick();
    set_m(1, 1'b0, '0);
    @(negedge clk);
    chk_gnt("stable_second", 0);
    chk("stable_addr2", s_req.addr, 32'h200);
    push_exp(0);
    tick();
    idle();
    give_rvalid();
    @(negedge clk);
    tick();
    give_rvalid();
    @(negedge clk);
    tick();

    // Outstanding limit: two handshakes, then stall until a response frees a slot.
    do_reset();
    s_resp.gnt = 1'b1;
    set_m(0, 1'b1, 32'h300);
    set_m(1, 1'b1, 32'h304);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("limit_req", 32'(s_req.req), (c < 2) ? 32'd1 : 32'd0);
      chk_gnt("limit_gnt", (c < 2) ? c : -1);
      if (c < 2) push_exp(c);
      tick();
    end
    give_rvalid();
    @(negedge clk);
    chk("limit_reissue", 32'(s_req.req), 32'd1);
    chk_gnt("limit_regnt", 0);
    push_exp(0);
    tick();

    // Full FIFO with a pop and push every cycle.
    for (int i = 0; i < 10; i++) begin
      set_m(0, mask_tab[i][0], 32'h400 + 32'(i));
      set_m(1, mask_tab[i][1], 32'h500 + 32'(i));
      give_rvalid();
      @(negedge clk);
      chk("pp_req", 32'(s_req.req), 32'd1);
      chk_gnt("pp_gnt", sel_tab[i]);
      push_exp(sel_tab[i]);
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      give_rvalid();
      @(negedge clk);
      tick();
    end
    chk("pp_drained", 32'(exp_q.size()), 32'd0);

    // Spurious response with nothing outstanding.
    give_rvalid();
    @(negedge clk);
    chk("spur_rv0", 32'(m_resp[0].rvalid), 32'd0);
    chk("spur_rv1", 32'(m_resp[1].rvalid), 32'd0);
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("spur_err", 32'(err), 32'd1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("spur_clear", 32'(err), 32'd0);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
Upstream stage of the peripheral subsystem. Merges NumMasters OBI initiator ports into the single OBI request that feeds the peripheral system's slave port (slave_req_i/slave_resp_o). Round-robin arbitration keeps requests stable until granted. An in-order ID FIFO returns each rvalid/rdata to the master that issued the request.

Parameters:
NumMasters, 2, number of upstream OBI initiators (2..8)
MaxOutstanding, 2, depth of the ID FIFO, i.e. granted-but-unanswered transactions (1..8)
IdxW, $clog2(NumMasters) (min 1), derived, master index width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
master_req_i  in  NumMasters x obi_req_t  per-master request (req, we, be[3:0], addr[31:0], wdata[31:0])
master_resp_o  out  NumMasters x obi_resp_t  per-master response (gnt, rvalid, rdata[31:0])
slave_req_o  out  obi_req_t  merged request to the peripheral system
slave_resp_i  in  obi_resp_t  response from the peripheral system
err_o  out  1  sticky: rvalid seen with no outstanding transaction

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values:
  - rr_q=0, lock_v_q=0, lock_idx_q=0, FIFO empty (rd/wr ptr 0, count 0), err_o=0.
  - While rst_i=1: slave_req_o.req=0, all master gnt=0, all master rvalid=0.
- Slot availability: can_issue = (count < MaxOutstanding) OR (slave rvalid this cycle). Pop frees a slot in the same cycle.
- Selection:
  - If lock_v_q=1, sel = lock_idx_q.
  - Otherwise sel = first requesting master found searching from rr_q upward, wrapping at NumMasters-1 back to 0.
- Forwarding: slave_req_o = master_req_i[sel] with req gated by can_issue and any_req. When not forwarding, all fields are 0.
- Grant: master_resp_o[sel].gnt = slave_resp_i.gnt AND slave_req_o.req. All other gnt=0. Combinational, 0-cycle path.
- Handshake: hs = slave_req_o.req AND slave_resp_i.gnt. On hs:
  - push sel into the FIFO;
  - rr_q <= (sel+1) mod NumMasters;
  - lock_v_q <= 0.
- Stability lock: slave_req_o.req=1 AND gnt=0 sets lock_v_q<=1 and lock_idx_q<=sel. Address and data stay on the same master until granted (OBI stability rule).
- Response routing:
  - slave_resp_i.rvalid with FIFO non-empty: master_resp_o[head].rvalid=1 and rdata=slave_resp_i.rdata, then pop.
  - All other masters: rvalid=0, rdata=0.
  - Response latency 0 cycles.
- Boundary cases:
  - Push and pop in the same cycle: count unchanged, both pointers advance (wrap at MaxOutstanding-1).
  - FIFO full with no rvalid: slave_req_o.req=0 and no gnt issued, even if lock_v_q=1. Lock is held.
  - rvalid with FIFO empty: dropped (no master rvalid), err_o<=1. err_o clears only on reset.
  - Locked master drops req before gnt (protocol violation): lock_v_q<=0 next cycle, selection resumes from rr_q.
  - Reset mid-transaction clears the FIFO and lock immediately. Outstanding responses arriving after reset raise err_o.
- Arithmetic: pointers and count are unsigned. Count width is $clog2(MaxOutstanding+1). rr increments modulo NumMasters, not modulo 2^IdxW.

Optional Feature:
OBI_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index requesting master wins. rr_q is neither instantiated nor updated. The stability lock still applies.
- Undefined: round-robin as described above.

Test Plan:
- Reset/idle: assert rst_i for 3 cycles with master 0 requesting -> slave_req_o.req=0, gnt=0, err_o=0. After release with slave gnt=1 -> master 0 granted on the first cycle.
- Round-robin: both masters req continuously, slave gnt=1, rvalid 1 cycle later -> grants alternate 0,1,0,1. Each master receives its own rdata (0xA0/0xB1 tagged by addr).
- Stability: master 1 requests at addr 0x100 with slave gnt=0 for 4 cycles while master 0 also requests -> slave_req_o.addr stays 0x100 for all 4 cycles. Master 1 is granted first, then master 0.
- Outstanding limit: MaxOutstanding=2, no rvalid for 5 cycles -> exactly 2 handshakes, then slave_req_o.req=0. Next rvalid returns data to the first-issued master, and req reasserts in the same cycle.
- Simultaneous push/pop: FIFO full, rvalid and a new request in the same cycle -> grant issued, count stays 2, ordering preserved over 10 random transactions.
- Spurious response: rvalid=1 with FIFO empty -> no master rvalid, err_o=1 and stays 1 until rst_i.
